api_sched: RTL

- Job scheduler between the API register slave's TX/RX FIFOs and the serial shift engine.
- Waits until a full job for the current channel is in the TX FIFO and its result will fit in the RX FIFO.
- Streams the job to the engine, waits for completion under the software-programmed timeout, returns the result words to the RX FIFO, then advances round-robin to the next channel.
- Its state code is the 3-bit reg_state readable through the state register.

---
 rtl/api_sched_pkg.sv | 19 +
 rtl/api_sched_if.sv | 25 ++
 rtl/api_sched_tmr.sv | 28 ++
 rtl/api_sched.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/api_sched_pkg.sv
// rtl/api_sched_pkg.sv - shared state codes and widths for the job scheduler
package api_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SEND = 3'd1,
        ST_WAIT = 3'd2,
        ST_RECV = 3'd3,
        ST_NEXT = 3'd4
    } state_t;

    localparam int DEF_JOB_WORDS = 4;
    localparam int DEF_RX_DEPTH  = 256;
    localparam int CNT_W         = 12;
    localparam int TMR_W         = 28;
    localparam int CH_W          = 6;
    localparam int DATA_W        = 32;

endpackage

// File: rtl/api_sched_if.sv
// rtl/api_sched_if.sv - scheduler to shift-engine handshake bundle
interface api_sched_if;
    import api_sched_pkg::*;

    logic [CH_W-1:0]   eng_ch;
    logic              eng_tx_valid;
    logic [DATA_W-1:0] eng_tx_data;
    logic              eng_tx_ready;
    logic              eng_done;
    logic              eng_rx_valid;
    logic [DATA_W-1:0] eng_rx_data;
    logic              eng_rx_ready;
    logic              eng_abort;

    modport master (
        output eng_ch, eng_tx_valid, eng_tx_data, eng_rx_ready, eng_abort,
        input  eng_tx_ready, eng_done, eng_rx_valid, eng_rx_data
    );

    modport slave (
        input  eng_ch, eng_tx_valid, eng_tx_data, eng_rx_ready, eng_abort,
        output eng_tx_ready, eng_done, eng_rx_valid, eng_rx_data
    );

endinterface

// File: rtl/api_sched_tmr.sv
// rtl/api_sched_tmr.sv - completion timeout counter for the WAIT phase
module api_sched_tmr
    import api_sched_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [TMR_W-1:0] timeout,
    output logic             expire
);

    logic [TMR_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + TMR_W'(1);
        end
    end

    // A zero timeout disables expiry entirely.
    assign expire = en && (timeout != '0) && (cnt == timeout - TMR_W'(1));

endmodule

// File: rtl/api_sched.sv
// rtl/api_sched.sv - round-robin job scheduler between API FIFOs and shift engine
module api_sched
    import api_sched_pkg::*;
#(
    parameter int JOB_WORDS = DEF_JOB_WORDS,
    parameter int RX_DEPTH  = DEF_RX_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reg_flush,
    input  logic [TMR_W-1:0]  reg_timeout,
    input  logic [CH_W-1:0]   reg_ch_num,
    input  logic [CH_W-1:0]   reg_chip_num,
    input  logic [9:0]        txcnt,
    input  logic              txempty,
    input  logic [DATA_W-1:0] txfifo_dout,
    output logic              txfifo_pop,
    input  logic [8:0]        rxcnt,
    output logic              rxfifo_push,
    output logic [DATA_W-1:0] rxfifo_din,
    api_sched_if.master       eng,
    output logic [2:0]        reg_state,
    output logic              timeout_err
);

    localparam logic [CNT_W-1:0] JOB_W = CNT_W'(JOB_WORDS);
    localparam logic [CNT_W-1:0] RX_D  = CNT_W'(RX_DEPTH);

    state_t            state;
    state_t            state_nx;
    logic [CNT_W-1:0]  wcnt;
    logic [CNT_W-1:0]  need;
    logic [CNT_W-1:0]  rx_free;
    logic [CH_W-1:0]   chn;
    logic              job_ready;
    logic              last_word;
    logic              tx_xfer;
    logic              rx_xfer;
    logic              tmr_expire;
    logic              tmr_clr;
    logic              tmr_en;

    assign need      = CNT_W'(reg_chip_num) * JOB_W;
    assign chn       = (reg_ch_num == '0) ? CH_W'(1) : reg_ch_num;
    assign rx_free   = RX_D - CNT_W'(rxcnt);
    assign job_ready = (reg_chip_num != '0) && (CNT_W'(txcnt) >= need) && (rx_free >= need);
    assign last_word = (wcnt == need - CNT_W'(1));
    assign reg_state = state;

    assign eng.eng_tx_data = txfifo_dout;

    assign tmr_en  = (state == ST_WAIT);
    assign tmr_clr = (state != ST_WAIT) || reg_flush;

    api_sched_tmr u_tmr (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .timeout (reg_timeout),
        .expire  (tmr_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx         = state;
        eng.eng_tx_valid = 1'b0;
        eng.eng_rx_ready = 1'b0;
        tx_xfer          = 1'b0;
        rx_xfer          = 1'b0;
        txfifo_pop       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (job_ready) state_nx = ST_SEND;
            end
            ST_SEND: begin
                eng.eng_tx_valid = !txempty && !reg_flush;
                tx_xfer          = eng.eng_tx_valid && eng.eng_tx_ready;
                txfifo_pop       = tx_xfer;
                if (tx_xfer && last_word) state_nx = ST_WAIT;
            end
            ST_WAIT: begin
                // Completion beats a coincident timeout.
                if (eng.eng_done)    state_nx = ST_RECV;
                else if (tmr_expire) state_nx = ST_NEXT;
            end
            ST_RECV: begin
                eng.eng_rx_ready = !reg_flush;
                rx_xfer          = eng.eng_rx_valid && eng.eng_rx_ready;
                if (rx_xfer && last_word) state_nx = ST_NEXT;
            end
            ST_NEXT: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
        if (reg_flush) state_nx = ST_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt          <= '0;
            eng.eng_ch    <= '0;
            eng.eng_abort <= 1'b0;
            rxfifo_push   <= 1'b0;
            rxfifo_din    <= '0;
            timeout_err   <= 1'b0;
        end else begin
            rxfifo_push   <= rx_xfer;
            eng.eng_abort <= 1'b0;
            if (rx_xfer) rxfifo_din <= eng.eng_rx_data;
            if (reg_flush) begin
                wcnt          <= '0;
                eng.eng_ch    <= '0;
                timeout_err   <= 1'b0;
                eng.eng_abort <= (state == ST_SEND) || (state == ST_WAIT) || (state == ST_RECV);
            end else begin
                if (tx_xfer || rx_xfer) begin
                    wcnt <= last_word ? '0 : wcnt + CNT_W'(1);
                end
                if ((state == ST_WAIT) && !eng.eng_done && tmr_expire) begin
                    eng.eng_abort <= 1'b1;
                    timeout_err   <= 1'b1;
                end
                // Wrap also covers a channel count that shrank below the pointer.
                if (state == ST_NEXT) begin
                    eng.eng_ch <= (({1'b0, eng.eng_ch} + 7'd1) >= {1'b0, chn}) ? '0 : eng.eng_ch + CH_W'(1);
                end
            end
        end
    end

endmodule
